// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch pointer, committed PC, retired-PC history,
// jump alignment checking and AD bus address multiplexing.

module pc_hist_cell #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end
endmodule

module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              IALIGN       = 4,
  parameter int              HISTORY      = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  localparam int             SEL_W        = (HISTORY > 1) ? $clog2(HISTORY) : 1,
  localparam int             CNT_W        = $clog2(HISTORY + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             advance,
  input  logic             step_half,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             addr_sel,
  input  logic             use_offset,
  input  logic [XLEN-1:0]  address_in,
  input  logic [SEL_W-1:0] history_sel,
  output logic [XLEN-1:0]  next,
  output logic [XLEN-1:0]  current,
  output logic [XLEN-1:0]  history_out,
  output logic [CNT_W-1:0] history_count,
  output logic [1:0]       data_offset,
  output logic [XLEN-1:0]  ad_bus,
  output logic             misalign_fault,
  output logic [XLEN-1:0]  fault_addr
);
  localparam logic [1:0] ALIGN_MASK = (IALIGN == 2) ? 2'b01 : 2'b11;
  localparam int         TAB_N      = 2 ** SEL_W;

  logic                            misalign;
  logic                            jump_ok;
  logic                            jump_bad;
  logic                            do_adv;
  logic [XLEN-1:0]                 step;
  logic [HISTORY-1:0][XLEN-1:0]    hist;
  logic [TAB_N-1:0][XLEN-1:0]      hist_tab;

  assign misalign = |(jump_target[1:0] & ALIGN_MASK);
  assign jump_ok  = jump & ~misalign;
  assign jump_bad = jump & misalign;
  // An accepted jump owns the cycle; a rejected one lets advance proceed.
  assign do_adv   = advance & ~jump_ok;
  assign step     = (IALIGN == 2 && step_half) ? XLEN'(2) : XLEN'(4);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      next           <= RESET_VECTOR;
      current        <= RESET_VECTOR;
      history_count  <= '0;
      data_offset    <= '0;
      misalign_fault <= 1'b0;
      fault_addr     <= '0;
    end else begin
      if (jump_ok)     next <= jump_target;
      else if (do_adv) next <= next + step;
      if (do_adv) begin
        current <= next;
        if (history_count != CNT_W'(HISTORY)) history_count <= history_count + 1'b1;
      end
      if (addr_sel) data_offset <= address_in[1:0];
      misalign_fault <= jump_bad;
      if (jump_bad) fault_addr <= jump_target;
    end
  end

  // History is a shift chain: entry 0 takes current, entry i takes entry i-1.
  for (genvar i = 0; i < HISTORY; i++) begin : g_hist
    logic [XLEN-1:0] d;
    if (i == 0) begin : g_head
      assign d = current;
    end else begin : g_tail
      assign d = hist[i-1];
    end
    pc_hist_cell #(.W(XLEN)) u_cell (
      .clock (clock),
      .reset (reset),
      .en    (do_adv),
      .d     (d),
      .q     (hist[i])
    );
  end

  // Pad the select space so out-of-range selects read as zero.
  for (genvar j = 0; j < TAB_N; j++) begin : g_tab
    if (j < HISTORY) begin : g_live
      assign hist_tab[j] = hist[j];
    end else begin : g_pad
      assign hist_tab[j] = '0;
    end
  end

  assign history_out = hist_tab[history_sel];

  always_comb begin
    ad_bus = next;
    if (addr_sel) ad_bus = use_offset ? address_in : {address_in[XLEN-1:2], 2'b00};
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one IALIGN=4/HISTORY=2 instance and one
// IALIGN=2/HISTORY=3 instance driven from a single linear sequence.
`timescale 1ns/1ps
module tb_pc_sequencer;
  logic clock, reset;

  logic        adv4, sh4, jump4, asel4, uoff4, hsel4;
  logic [31:0] jt4, ai4;
  logic [31:0] next4, cur4, hout4, ad4, faddr4;
  logic [1:0]  cnt4, doff4;
  logic        flt4;

  logic        adv2, sh2, jump2, asel2, uoff2;
  logic [1:0]  hsel2;
  logic [31:0] jt2, ai2;
  logic [31:0] next2, cur2, hout2, ad2, faddr2;
  logic [1:0]  cnt2, doff2;
  logic        flt2;

  int errors = 0;
  int checks = 0;

  pc_sequencer #(.XLEN(32), .IALIGN(4), .HISTORY(2), .RESET_VECTOR(32'h100)) u4 (
    .clock(clock), .reset(reset), .advance(adv4), .step_half(sh4), .jump(jump4),
    .jump_target(jt4), .addr_sel(asel4), .use_offset(uoff4), .address_in(ai4),
    .history_sel(hsel4), .next(next4), .current(cur4), .history_out(hout4),
    .history_count(cnt4), .data_offset(doff4), .ad_bus(ad4),
    .misalign_fault(flt4), .fault_addr(faddr4));

  pc_sequencer #(.XLEN(32), .IALIGN(2), .HISTORY(3), .RESET_VECTOR(32'h200)) u2 (
    .clock(clock), .reset(reset), .advance(adv2), .step_half(sh2), .jump(jump2),
    .jump_target(jt2), .addr_sel(asel2), .use_offset(uoff2), .address_in(ai2),
    .history_sel(hsel2), .next(next2), .current(cur2), .history_out(hout2),
    .history_count(cnt2), .data_offset(doff2), .ad_bus(ad2),
    .misalign_fault(flt2), .fault_addr(faddr2));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    clock = 0; reset = 0;
    adv4 = 0; sh4 = 0; jump4 = 0; asel4 = 0; uoff4 = 0; hsel4 = 0; jt4 = 0; ai4 = 0;
    adv2 = 0; sh2 = 0; jump2 = 0; asel2 = 0; uoff2 = 0; hsel2 = 0; jt2 = 0; ai2 = 0;
    #12;
    chk("rst4_next", next4, 32'h100);
    chk("rst4_cur", cur4, 32'h100);
    chk("rst4_cnt", 32'(cnt4), 0);
    chk("rst4_hist", hout4, 0);
    chk("rst4_flt", 32'(flt4), 0);
    chk("rst4_faddr", faddr4, 0);
    chk("rst4_doff", 32'(doff4), 0);
    chk("rst2_next", next2, 32'h200);
    reset = 1;

    // three sequential advances
    adv4 = 1;
    tick();
    chk("a1_next", next4, 32'h104);
    chk("a1_cur", cur4, 32'h100);
    chk("a1_cnt", 32'(cnt4), 1);
    chk("a1_h0", hout4, 32'h100);
    tick(); tick();
    chk("a3_next", next4, 32'h10C);
    chk("a3_cur", cur4, 32'h108);
    chk("a3_cnt", 32'(cnt4), 2);
    chk("a3_h0", hout4, 32'h104);
    hsel4 = 1; #1;
    chk("a3_h1", hout4, 32'h100);
    hsel4 = 0;

    // step_half ignored at IALIGN=4
    sh4 = 1;
    tick();
    sh4 = 0;
    chk("half4_next", next4, 32'h110);
    chk("half4_cur", cur4, 32'h10C);
    chk("half4_cnt", 32'(cnt4), 2);

    // jump beats advance
    jump4 = 1; jt4 = 32'h80;
    tick();
    jump4 = 0;
    chk("jmp_next", next4, 32'h80);
    chk("jmp_cur", cur4, 32'h10C);
    chk("jmp_h0", hout4, 32'h108);
    tick();
    adv4 = 0;
    chk("jadv_cur", cur4, 32'h80);
    chk("jadv_next", next4, 32'h84);
    chk("jadv_h0", hout4, 32'h10C);

    // back-to-back jumps
    jump4 = 1; jt4 = 32'h200;
    tick();
    jt4 = 32'h300;
    tick();
    jump4 = 0;
    chk("b2b_next", next4, 32'h300);

    // misaligned jump with concurrent advance
    jump4 = 1; jt4 = 32'h1002; adv4 = 1;
    tick();
    jump4 = 0; adv4 = 0;
    chk("mis_flt", 32'(flt4), 1);
    chk("mis_faddr", faddr4, 32'h1002);
    chk("mis_next", next4, 32'h304);
    chk("mis_cur", cur4, 32'h300);
    tick();
    chk("mis_flt_clr", 32'(flt4), 0);
    chk("mis_faddr_hold", faddr4, 32'h1002);
    chk("mis_next_hold", next4, 32'h304);

    // wrap-around
    jump4 = 1; jt4 = 32'hFFFF_FFFC;
    tick();
    jump4 = 0;
    chk("wrap_pre", next4, 32'hFFFF_FFFC);
    adv4 = 1;
    tick();
    adv4 = 0;
    chk("wrap_next", next4, 32'h0);
    chk("wrap_cur", cur4, 32'hFFFF_FFFC);

    // AD bus and data offset
    asel4 = 1; ai4 = 32'h3007; #1;
    chk("ad_mask", ad4, 32'h3004);
    tick();
    chk("doff", 32'(doff4), 3);
    uoff4 = 1; #1;
    chk("ad_raw", ad4, 32'h3007);
    asel4 = 0; uoff4 = 0; ai4 = 32'h5; adv4 = 1;
    tick();
    adv4 = 0;
    chk("ad_next", ad4, 32'h4);
    chk("doff_hold", 32'(doff4), 3);

    // compressed instance
    adv2 = 1; sh2 = 1;
    tick();
    sh2 = 0;
    chk("c1_next", next2, 32'h202);
    chk("c1_cur", cur2, 32'h200);
    tick();
    chk("c2_next", next2, 32'h206);
    chk("c2_cur", cur2, 32'h202);
    tick(); tick();
    adv2 = 0;
    chk("c4_cnt", 32'(cnt2), 3);
    chk("c4_next", next2, 32'h20E);
    chk("c4_cur", cur2, 32'h20A);
    hsel2 = 0; #1; chk("c4_h0", hout2, 32'h206);
    hsel2 = 1; #1; chk("c4_h1", hout2, 32'h202);
    hsel2 = 2; #1; chk("c4_h2", hout2, 32'h200);
    hsel2 = 3; #1; chk("c4_h3_oob", hout2, 32'h0);
    hsel2 = 0;
    jump2 = 1; jt2 = 32'h1002;
    tick();
    chk("c_jmp_next", next2, 32'h1002);
    chk("c_jmp_flt", 32'(flt2), 0);
    jt2 = 32'h1003; adv2 = 1;
    tick();
    jump2 = 0; adv2 = 0;
    chk("c_mis_flt", 32'(flt2), 1);
    chk("c_mis_faddr", faddr2, 32'h1003);
    chk("c_mis_next", next2, 32'h1006);
    chk("c_mis_cur", cur2, 32'h1002);

    // async reset mid-cycle with pending misaligned jump and advance
    @(posedge clock); #3;
    adv4 = 1; jump4 = 1; jt4 = 32'h1001; adv2 = 1;
    #1 reset = 0;
    #1;
    chk("ar_next", next4, 32'h100);
    chk("ar_cur", cur4, 32'h100);
    chk("ar_cnt", 32'(cnt4), 0);
    chk("ar_h0", hout4, 0);
    chk("ar_doff", 32'(doff4), 0);
    chk("ar_flt", 32'(flt4), 0);
    chk("ar_faddr", faddr4, 0);
    chk("ar_ad", ad4, 32'h100);
    chk("ar2_next", next2, 32'h200);
    chk("ar2_cnt", 32'(cnt2), 0);
    tick();
    chk("ar_hold_flt", 32'(flt4), 0);
    chk("ar_hold_next", next4, 32'h100);
    adv4 = 0; jump4 = 0; adv2 = 0;
    #2 reset = 1;
    tick();
    chk("post_rst_next", next4, 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
